oclib_averager_multi: RTL and testbench
=======================================

Name: oclib_averager_multi

Overview:
- Multi-channel exponential moving averager (leaky integrator) with a runtime-selectable time constant.
- Samples arrive time-multiplexed, each tagged with a channel index; each channel keeps its own accumulator.
- Adds per-channel clear, optional fast-start priming, output-preserving time-constant reload and a tagged result stream.
- Sits between samplers/monitors (utilisation, occupancy, sensor bits) and CSR readback or threshold logic.

Parameters:
- InWidth, 1, sample width; must satisfy InWidth <= OutWidth
- OutWidth, 9, width of each averaged output
- NumChannels, 4, number of independent averaging channels (>= 1)
- MaxTimeShift, 8, largest supported time-constant shift
- Prime, 1, 1 = first sample after a clear loads the accumulator directly; 0 = integrate from zero

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-low reset
- in  input  InWidth  sample
- inValid  input  1  sample strobe
- inChannel  input  $clog2(NumChannels) (min 1)  channel the sample belongs to
- clear  input  NumChannels  per-channel synchronous clear
- cfgLoad  input  1  strobe: load cfgTimeShift
- cfgTimeShift  input  $clog2(MaxTimeShift+1)  requested time-constant shift
- timeShift  output  $clog2(MaxTimeShift+1)  active shift
- outValid  output  1  one-cycle result strobe
- outChannel  output  $clog2(NumChannels)  channel of the result
- out  output  OutWidth  updated average of outChannel
- outAll  output  NumChannels*OutWidth  all channel averages; channel 0 in the LSBs

Behaviour:
- Constants:
  - TotalWidth = OutWidth + MaxTimeShift
  - InShift = OutWidth - InWidth
- Per channel c:
  - Accumulator acc[c], TotalWidth bits.
  - primed[c] flag.
  - Average avg[c] = acc[c] >> timeShift, truncated to OutWidth.
- Reset (asserted low, async):
  - acc = 0, primed = 0, timeShift = MaxTimeShift.
  - outValid = 0, outChannel = 0, out = 0, outAll = 0.
- Update on inValid for channel k:
  - x = in << InShift, zero-extended.
  - acc[k] <= acc[k] + x - (acc[k] >> timeShift).
  - Intermediate sum is TotalWidth+1 bits; result is written back as TotalWidth bits and cannot overflow.
- timeShift = 0: acc[k] <= x, i.e. the average equals the latest sample.
- Prime = 1 and primed[k] = 0:
  - acc[k] <= x << timeShift and primed[k] <= 1.
  - The average equals the sample immediately.
- Latency: result registered 1 cycle after inValid.
  - outValid = 1, outChannel = k, out = new avg[k].
  - outAll reflects the same update on the same cycle.
- inChannel >= NumChannels: sample dropped, no state change, outValid stays 0.
- clear[c]:
  - acc[c] <= 0, primed[c] <= 0.
  - Same cycle as inValid on channel c: clear wins, sample discarded, outValid = 0 next cycle.
- cfgLoad:
  - timeShift <= min(cfgTimeShift, MaxTimeShift).
  - Every channel is rescaled so its average is preserved: acc[c] <= avg[c] << newShift.
  - Coincident cfgLoad + inValid: rescale first, then the sample is applied with the new shift in the same cycle.
  - clear on the same cycle still wins for its channel.
- No back-pressure: one sample per cycle sustained, all channels.
- Reset mid-stream: all state returns to reset values; a pending outValid is lost.

Test Plan (InWidth=1, OutWidth=9, NumChannels=4, MaxTimeShift=8, Prime=0 unless stated):
- Reset, then in=1 on ch0 every cycle for 3000 cycles -> out rises monotonically, reaches and holds 256 (acc = 65536); outAll ch1..3 remain 0.
- cfgLoad cfgTimeShift=0, then one in=1 on ch2 -> next cycle outValid=1, outChannel=2, out=256; then in=0 -> out=0.
- Prime=1, shift 8, first sample in=1 on ch1 -> out=256 one cycle later; second sample in=0 -> out=255.
- ch0 settled at 256, cfgLoad cfgTimeShift=4 -> avg[0] stays 256, timeShift=4. Then in=0 repeatedly -> out halves roughly every 11 samples, reaching 0.
- inValid on ch3 with clear[3] in the same cycle -> outValid=0, avg[3]=0. inChannel=5 (with NumChannels=5 built for 3-bit index), or an out-of-range index -> dropped, no outValid.
- Drop reset low asynchronously mid-stream between clock edges -> outputs go to 0 immediately; timeShift reads 8 after release.

Source files
------------

// File: rtl/oclib_averager_multi.sv
// Multi-channel leaky-integrator averager with per-channel clear, optional priming and live time-constant reload.
// Latency: one cycle from an accepted sample to outValid/out; outAll tracks the registered accumulators.
// Backpressure: none; one sample per cycle is accepted on any channel, out-of-range channels are dropped.
module oclib_averager_multi #(
    parameter int InWidth      = 1,
    parameter int OutWidth     = 9,
    parameter int NumChannels  = 4,
    parameter int MaxTimeShift = 8,
    parameter int Prime        = 1,
    localparam int ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int ShiftWidth  = $clog2(MaxTimeShift + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [InWidth-1:0]              in,
    input  logic                            inValid,
    input  logic [ChanWidth-1:0]            inChannel,
    input  logic [NumChannels-1:0]          clear,
    input  logic                            cfgLoad,
    input  logic [ShiftWidth-1:0]           cfgTimeShift,
    output logic [ShiftWidth-1:0]           timeShift,
    output logic                            outValid,
    output logic [ChanWidth-1:0]            outChannel,
    output logic [OutWidth-1:0]             out,
    output logic [NumChannels*OutWidth-1:0] outAll
);

    // Accumulator holds the average scaled by 2^timeShift, so the top OutWidth bits
    // of the widest setting are the average and the rest are fractional history.
    localparam int TotalWidth = OutWidth + MaxTimeShift;
    localparam int InShift    = OutWidth - InWidth;
    localparam logic [ShiftWidth-1:0] MaxShift = ShiftWidth'(MaxTimeShift);

    logic [TotalWidth-1:0]  acc      [NumChannels];
    logic [TotalWidth-1:0]  acc_nxt  [NumChannels];
    logic [OutWidth-1:0]    avg_cur  [NumChannels];
    logic [NumChannels-1:0] primed;
    logic [NumChannels-1:0] primed_nxt;
    logic [ShiftWidth-1:0]  shift_nxt;
    logic [TotalWidth-1:0]  x;
    logic [TotalWidth-1:0]  base;
    logic [TotalWidth:0]    sum;
    logic [TotalWidth-1:0]  cur_tmp;
    logic [TotalWidth-1:0]  new_tmp;
    logic                   res_vld;
    logic [OutWidth-1:0]    res_avg;

    // Sample is left-aligned into the output range so a 1-bit input averages to a duty cycle.
    assign x = TotalWidth'(in) << InShift;

    // Current per-channel averages from the registered state.
    always_comb begin
        cur_tmp = '0;
        for (int c = 0; c < NumChannels; c++) begin
            cur_tmp    = acc[c] >> timeShift;
            avg_cur[c] = cur_tmp[OutWidth-1:0];
            outAll[c*OutWidth +: OutWidth] = cur_tmp[OutWidth-1:0];
        end
    end

    // Next-state: rescale on reload, then clear or integrate the sample with the new shift.
    always_comb begin
        shift_nxt = timeShift;
        if (cfgLoad) begin
            shift_nxt = (cfgTimeShift > MaxShift) ? MaxShift : cfgTimeShift;
        end
        primed_nxt = primed;
        res_vld    = 1'b0;
        res_avg    = '0;
        base       = '0;
        sum        = '0;
        new_tmp    = '0;
        for (int c = 0; c < NumChannels; c++) begin
            // Reload keeps each average intact by re-expanding it at the new scale.
            base = cfgLoad ? (TotalWidth'(avg_cur[c]) << shift_nxt) : acc[c];
            sum  = (TotalWidth+1)'(base) + (TotalWidth+1)'(x)
                 - (TotalWidth+1)'(base >> shift_nxt);
            acc_nxt[c] = base;
            if (clear[c]) begin
                acc_nxt[c]    = '0;
                primed_nxt[c] = 1'b0;
            end else if (inValid && (inChannel == ChanWidth'(c))) begin
                primed_nxt[c] = 1'b1;
                if ((Prime != 0) && !primed[c]) begin
                    acc_nxt[c] = x << shift_nxt;
                end else if (shift_nxt == '0) begin
                    acc_nxt[c] = x;
                end else begin
                    // Steady state is bounded by x << shift, so the top bit of sum is never set.
                    acc_nxt[c] = sum[TotalWidth-1:0];
                end
                new_tmp = acc_nxt[c] >> shift_nxt;
                res_avg = new_tmp[OutWidth-1:0];
                res_vld = 1'b1;
            end
        end
    end

    // State and result registers; outChannel/out hold their last value between strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NumChannels; c++) begin
                acc[c] <= '0;
            end
            primed     <= '0;
            timeShift  <= MaxShift;
            outValid   <= 1'b0;
            outChannel <= '0;
            out        <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                acc[c] <= acc_nxt[c];
            end
            primed    <= primed_nxt;
            timeShift <= shift_nxt;
            outValid  <= res_vld;
            if (res_vld) begin
                outChannel <= inChannel;
                out        <= res_avg;
            end
        end
    end

endmodule

// File: tb/tb_oclib_averager_multi.sv
// Testbench for oclib_averager_multi: dut a (4 channels, no priming) and dut b (5 channels, priming).
// Reference model recomputes each channel with plain integer arithmetic from the averaging rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_oclib_averager_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_in, a_vld, b_in, b_vld, cfg_load;
    logic [1:0]  a_ch;
    logic [3:0]  a_clr;
    logic [2:0]  b_ch;
    logic [4:0]  b_clr;
    logic [3:0]  cfg_shift;
    logic [3:0]  a_ts, b_ts;
    logic        a_ov, b_ov;
    logic [1:0]  a_och;
    logic [2:0]  b_och;
    logic [8:0]  a_out, b_out;
    logic [35:0] a_all;
    logic [44:0] b_all;

    int errors = 0;
    int checks = 0;

    // Reference state
    longint ma_acc [4];
    longint mb_acc [5];
    bit     mb_primed [5];
    int     m_shift;
    bit     ea_vld, eb_vld;
    int     ea_ch, ea_out, eb_ch, eb_out;

    always #5 clock = ~clock;

    oclib_averager_multi #(.InWidth(1), .OutWidth(9), .NumChannels(4), .MaxTimeShift(8), .Prime(0)) dut_a (
        .clock(clock), .reset(reset), .in(a_in), .inValid(a_vld), .inChannel(a_ch), .clear(a_clr),
        .cfgLoad(cfg_load), .cfgTimeShift(cfg_shift), .timeShift(a_ts), .outValid(a_ov),
        .outChannel(a_och), .out(a_out), .outAll(a_all));

    oclib_averager_multi #(.InWidth(1), .OutWidth(9), .NumChannels(5), .MaxTimeShift(8), .Prime(1)) dut_b (
        .clock(clock), .reset(reset), .in(b_in), .inValid(b_vld), .inChannel(b_ch), .clear(b_clr),
        .cfgLoad(cfg_load), .cfgTimeShift(cfg_shift), .timeShift(b_ts), .outValid(b_ov),
        .outChannel(b_och), .out(b_out), .outAll(b_all));

    function automatic longint pow2(int s);
        return longint'(1) << s;
    endfunction

    function automatic int avg_of(longint acc, int s);
        return int'((acc / pow2(s)) % 512);
    endfunction

    // One channel's next accumulator value, straight from the averaging rules.
    function automatic longint upd(longint acc, bit primed, bit prime_p, int old_s, int new_s,
                                   bit hit, bit clr, int x, bit cfg);
        longint a;
        a = cfg ? longint'(avg_of(acc, old_s)) * pow2(new_s) : acc;
        if (clr) return 0;
        if (!hit) return a;
        if (prime_p && !primed) return longint'(x) * pow2(new_s);
        if (new_s == 0) return longint'(x);
        return a + x - a / pow2(new_s);
    endfunction

    function automatic logic [35:0] exp_all_a();
        logic [35:0] v;
        for (int c = 0; c < 4; c++) v[c*9 +: 9] = 9'(avg_of(ma_acc[c], m_shift));
        return v;
    endfunction

    function automatic logic [44:0] exp_all_b();
        logic [44:0] v;
        for (int c = 0; c < 5; c++) v[c*9 +: 9] = 9'(avg_of(mb_acc[c], m_shift));
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) ma_acc[c] = 0;
        for (int c = 0; c < 5; c++) begin
            mb_acc[c] = 0;
            mb_primed[c] = 0;
        end
        m_shift = 8;
        ea_vld = 0; ea_ch = 0; ea_out = 0;
        eb_vld = 0; eb_ch = 0; eb_out = 0;
    endtask

    // Advance one clock: predict from the current inputs, then commit after the edge.
    task automatic tick();
        int     ns;
        longint na [4];
        longint nb [5];
        bit     nbp [5];
        bit     va, vb;
        ns = cfg_load ? ((int'(cfg_shift) > 8) ? 8 : int'(cfg_shift)) : m_shift;
        for (int c = 0; c < 4; c++)
            na[c] = upd(ma_acc[c], 1'b1, 1'b0, m_shift, ns, a_vld && int'(a_ch) == c,
                        a_clr[c], int'(a_in) * 256, cfg_load);
        for (int c = 0; c < 5; c++) begin
            nb[c] = upd(mb_acc[c], mb_primed[c], 1'b1, m_shift, ns, b_vld && int'(b_ch) == c,
                        b_clr[c], int'(b_in) * 256, cfg_load);
            nbp[c] = b_clr[c] ? 1'b0 : ((b_vld && int'(b_ch) == c) ? 1'b1 : mb_primed[c]);
        end
        va = a_vld && !a_clr[a_ch];
        vb = b_vld && (int'(b_ch) < 5) && !b_clr[b_ch];
        @(posedge clock);
        ma_acc = na;
        mb_acc = nb;
        mb_primed = nbp;
        m_shift = ns;
        ea_vld = va;
        eb_vld = vb;
        if (va) begin ea_ch = int'(a_ch); ea_out = avg_of(na[a_ch], ns); end
        if (vb) begin eb_ch = int'(b_ch); eb_out = avg_of(nb[b_ch], ns); end
        #1;
    endtask

    task automatic test_reset();
        checks++; if (a_ts !== 4'd8)  begin errors++; $display("FAIL reset a_ts: got %0d want 8", a_ts); end
        checks++; if (b_ts !== 4'd8)  begin errors++; $display("FAIL reset b_ts: got %0d want 8", b_ts); end
        checks++; if (a_ov !== 1'b0 || b_ov !== 1'b0) begin errors++; $display("FAIL reset outValid: got %b/%b want 0", a_ov, b_ov); end
        checks++; if (a_out !== 9'd0 || a_och !== 2'd0) begin errors++; $display("FAIL reset a_out: got %0d ch %0d want 0", a_out, a_och); end
        checks++; if (a_all !== 36'd0 || b_all !== 45'd0) begin errors++; $display("FAIL reset outAll: got %h/%h want 0", a_all, b_all); end
    endtask

    task automatic test_converge();
        int prev = 0;
        a_in = 1; a_vld = 1; a_ch = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            checks++; if (a_ov !== 1'b1 || a_och !== 2'd0) begin errors++; $display("FAIL converge strobe: got vld %b ch %0d want 1 ch 0", a_ov, a_och); end
            checks++; if (a_out !== 9'(ea_out)) begin errors++; $display("FAIL converge out: got %0d want %0d", a_out, ea_out); end
            checks++; if (int'(a_out) < prev) begin errors++; $display("FAIL converge monotonic: got %0d after %0d", a_out, prev); end
            prev = int'(a_out);
        end
        a_vld = 0;
        checks++; if (a_out !== 9'd256) begin errors++; $display("FAIL converge final: got %0d want 256", a_out); end
        checks++; if (a_all !== 36'd256) begin errors++; $display("FAIL converge outAll: got %h want %h", a_all, 36'd256); end
        checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL converge b idle: got %b want 0", b_ov); end
    endtask

    task automatic test_rescale();
        cfg_load = 1; cfg_shift = 4;
        tick();
        cfg_load = 0;
        checks++; if (a_ts !== 4'd4) begin errors++; $display("FAIL rescale ts: got %0d want 4", a_ts); end
        checks++; if (a_all[8:0] !== 9'd256) begin errors++; $display("FAIL rescale avg: got %0d want 256", a_all[8:0]); end
        a_in = 0; a_vld = 1; a_ch = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++; if (a_out !== 9'(ea_out)) begin errors++; $display("FAIL rescale decay: got %0d want %0d", a_out, ea_out); end
            if (i == 10) begin
                checks++; if (a_out > 9'd128 || a_out < 9'd100) begin errors++; $display("FAIL rescale half: got %0d want 100..128", a_out); end
            end
        end
        a_vld = 0;
        checks++; if (a_out !== 9'd0) begin errors++; $display("FAIL rescale zero: got %0d want 0", a_out); end
    endtask

    task automatic test_shift0();
        cfg_load = 1; cfg_shift = 0;
        tick();
        cfg_load = 0;
        checks++; if (a_ts !== 4'd0) begin errors++; $display("FAIL shift0 ts: got %0d want 0", a_ts); end
        a_in = 1; a_vld = 1; a_ch = 2;
        tick();
        checks++; if (a_ov !== 1'b1 || a_och !== 2'd2 || a_out !== 9'd256) begin errors++; $display("FAIL shift0 one: got vld %b ch %0d out %0d want 1 2 256", a_ov, a_och, a_out); end
        a_in = 0;
        tick();
        a_vld = 0;
        checks++; if (a_out !== 9'd0) begin errors++; $display("FAIL shift0 zero: got %0d want 0", a_out); end
    endtask

    task automatic test_prime();
        cfg_load = 1; cfg_shift = 12; b_clr = 5'b00010;
        tick();
        cfg_load = 0; b_clr = 0;
        checks++; if (a_ts !== 4'd8 || b_ts !== 4'd8) begin errors++; $display("FAIL prime clamp: got %0d/%0d want 8", a_ts, b_ts); end
        b_in = 1; b_vld = 1; b_ch = 1;
        tick();
        checks++; if (b_ov !== 1'b1 || b_och !== 3'd1 || b_out !== 9'd256) begin errors++; $display("FAIL prime first: got vld %b ch %0d out %0d want 1 1 256", b_ov, b_och, b_out); end
        b_in = 0;
        tick();
        b_vld = 0;
        checks++; if (b_out !== 9'd255) begin errors++; $display("FAIL prime second: got %0d want 255", b_out); end
    endtask

    task automatic test_clear_drop();
        logic [44:0] saved;
        a_in = 1; a_vld = 1; a_ch = 3; a_clr = 4'b1000;
        tick();
        a_vld = 0; a_clr = 0;
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL clear strobe: got %b want 0", a_ov); end
        checks++; if (a_all[35:27] !== 9'd0) begin errors++; $display("FAIL clear avg3: got %0d want 0", a_all[35:27]); end
        for (int ch = 5; ch < 8; ch++) begin
            saved = b_all;
            b_in = 1; b_vld = 1; b_ch = 3'(ch);
            tick();
            checks++; if (b_ov !== 1'b0 || b_all !== saved) begin errors++; $display("FAIL drop ch%0d: got vld %b all %h want 0 %h", ch, b_ov, b_all, saved); end
        end
        b_ch = 4;
        tick();
        b_vld = 0;
        checks++; if (b_ov !== 1'b1 || b_och !== 3'd4 || b_out !== 9'(eb_out)) begin errors++; $display("FAIL ch4: got vld %b ch %0d out %0d want 1 4 %0d", b_ov, b_och, b_out, eb_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            a_vld = 1'($urandom_range(0, 3) != 0); a_in = 1'($urandom); a_ch = 2'($urandom);
            b_vld = 1'($urandom_range(0, 3) != 0); b_in = 1'($urandom); b_ch = 3'($urandom);
            a_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
            b_clr = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'd0;
            cfg_load = ($urandom_range(0, 63) == 0);
            cfg_shift = 4'($urandom);
            tick();
            checks++; if (a_ov !== ea_vld) begin errors++; $display("FAIL rand a_vld: got %b want %b", a_ov, ea_vld); end
            if (ea_vld) begin
                checks++; if (a_och !== 2'(ea_ch) || a_out !== 9'(ea_out)) begin errors++; $display("FAIL rand a_out: got ch %0d out %0d want ch %0d out %0d", a_och, a_out, ea_ch, ea_out); end
            end
            checks++; if (a_all !== exp_all_a()) begin errors++; $display("FAIL rand a_all: got %h want %h", a_all, exp_all_a()); end
            checks++; if (b_ov !== eb_vld) begin errors++; $display("FAIL rand b_vld: got %b want %b", b_ov, eb_vld); end
            if (eb_vld) begin
                checks++; if (b_och !== 3'(eb_ch) || b_out !== 9'(eb_out)) begin errors++; $display("FAIL rand b_out: got ch %0d out %0d want ch %0d out %0d", b_och, b_out, eb_ch, eb_out); end
            end
            checks++; if (b_all !== exp_all_b()) begin errors++; $display("FAIL rand b_all: got %h want %h", b_all, exp_all_b()); end
            checks++; if (a_ts !== 4'(m_shift) || b_ts !== 4'(m_shift)) begin errors++; $display("FAIL rand ts: got %0d/%0d want %0d", a_ts, b_ts, m_shift); end
        end
        a_vld = 0; b_vld = 0; a_clr = 0; b_clr = 0; cfg_load = 0;
    endtask

    task automatic test_reset_mid();
        a_in = 1; a_vld = 1; a_ch = 1; b_in = 1; b_vld = 1; b_ch = 2;
        cfg_load = 1; cfg_shift = 3;
        tick();
        cfg_load = 0;
        repeat (4) tick();
        #3;
        reset = 0;
        #1;
        checks++; if (a_ov !== 1'b0 || b_ov !== 1'b0) begin errors++; $display("FAIL midreset strobe: got %b/%b want 0", a_ov, b_ov); end
        checks++; if (a_out !== 9'd0 || a_och !== 2'd0 || b_out !== 9'd0) begin errors++; $display("FAIL midreset out: got %0d/%0d want 0", a_out, b_out); end
        checks++; if (a_all !== 36'd0 || b_all !== 45'd0) begin errors++; $display("FAIL midreset outAll: got %h/%h want 0", a_all, b_all); end
        model_reset();
        a_vld = 0; b_vld = 0;
        @(negedge clock);
        reset = 1;
        tick();
        checks++; if (a_ts !== 4'd8 || b_ts !== 4'd8) begin errors++; $display("FAIL midreset ts: got %0d/%0d want 8", a_ts, b_ts); end
        checks++; if (a_ov !== 1'b0 || b_ov !== 1'b0) begin errors++; $display("FAIL midreset pending: got %b/%b want 0", a_ov, b_ov); end
    endtask

    initial begin
        reset = 0;
        a_in = 0; a_vld = 0; a_ch = 0; a_clr = 0;
        b_in = 0; b_vld = 0; b_ch = 0; b_clr = 0;
        cfg_load = 0; cfg_shift = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1;
        test_converge();
        test_rescale();
        test_shift0();
        test_prime();
        test_clear_drop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
